// File: rtl/seg7_reader_if.sv
// Signal bundle between a seven-segment source and the seg7_reader decoder.
// The master drives the pattern and the slave returns the decoded result.
interface seg7_reader_if;
    logic [7:0] seg_in;
    logic [3:0] value;
    logic       valid;
    logic       error;
    logic [7:0] change_count;
    logic [1:0] state;

    modport master (
        output seg_in,
        input  value,
        input  valid,
        input  error,
        input  change_count,
        input  state
    );

    modport slave (
        input  seg_in,
        output value,
        output valid,
        output error,
        output change_count,
        output state
    );
endinterface

// File: rtl/seg7_reader.sv
// Recovers the signed digit shown on a seven-segment pattern (bit 7 = minus)
// once the pattern has been stable for SETTLE_CYCLES consecutive samples.
module seg7_reader #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk_2,
    input  logic        rst_n,
    seg7_reader_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    localparam logic [3:0] CNT_MAX = 4'(SETTLE_CYCLES - 1);

    logic [7:0] s_reg;
    logic [3:0] cnt;
    logic [1:0] state_q;
    logic [3:0] value_q;
    logic       valid_q;
    logic       error_q;
    logic [7:0] count_q;
    logic       have_value;

    logic       changed;
    logic       settled;
    logic       dec_blank;
    logic       dec_legal;
    logic [2:0] dec_mag;
    logic [3:0] dec_value;

    assign changed = (bus.seg_in != s_reg);
    assign settled = !changed && (cnt == CNT_MAX);

    // Decode the held sample; "-0" folds to 0 and blank is checked separately
    // because its segment field alone would look illegal.
    always_comb begin
        dec_legal = 1'b1;
        dec_mag   = 3'd0;
        case (s_reg[6:0])
            7'h3F:        dec_mag = 3'd0;
            7'h06:        dec_mag = 3'd1;
            7'h5B:        dec_mag = 3'd2;
            7'h4F:        dec_mag = 3'd3;
            7'h66:        dec_mag = 3'd4;
            7'h6D:        dec_mag = 3'd5;
            7'h3D, 7'h7D: dec_mag = 3'd6;
            7'h07:        dec_mag = 3'd7;
            default:      dec_legal = 1'b0;
        endcase
        dec_blank = (s_reg == 8'h00);
        dec_value = s_reg[7] ? (4'd0 - {1'b0, dec_mag}) : {1'b0, dec_mag};
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            s_reg      <= 8'h00;
            cnt        <= 4'd0;
            state_q    <= ST_IDLE;
            value_q    <= 4'd0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= 8'd0;
            have_value <= 1'b0;
        end else begin
            s_reg <= bus.seg_in;

            if (changed) begin
                cnt <= 4'd0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 4'd1;
            end

            // Any change restarts settling from whatever state we are in.
            if (changed) begin
                state_q <= ST_SETTLE;
                valid_q <= 1'b0;
                error_q <= 1'b0;
            end else if (state_q == ST_SETTLE && settled) begin
                if (dec_blank) begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    error_q <= 1'b0;
                end else if (dec_legal) begin
                    state_q    <= ST_LOCKED;
                    value_q    <= dec_value;
                    valid_q    <= 1'b1;
                    error_q    <= 1'b0;
                    have_value <= 1'b1;
                    if (!have_value || dec_value != value_q) begin
                        count_q <= count_q + 8'd1;
                    end
                end else begin
                    state_q <= ST_ERROR;
                    valid_q <= 1'b0;
                    error_q <= 1'b1;
                end
            end
        end
    end

    assign bus.value        = value_q;
    assign bus.valid        = valid_q;
    assign bus.error        = error_q;
    assign bus.change_count = count_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: a run-length reference model is compared
// every cycle, plus literal expectations at key points of each scenario.
module tb_seg7_reader;

    localparam int SC = 4;

    logic clk_2 = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    seg7_reader_if bus ();

    seg7_reader #(.SETTLE_CYCLES(SC)) dut (
        .clk_2 (clk_2),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_2 = ~clk_2;

    logic [6:0] pat_tab [9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h3D, 7'h7D, 7'h07};
    int         dig_tab [9] = '{0, 1, 2, 3, 4, 5, 6, 6, 7};

    // 0 = blank, 1 = legal digit, 2 = illegal
    function automatic int model_kind(input logic [7:0] p);
        if (p == 8'h00) return 0;
        for (int i = 0; i < 9; i++) if (pat_tab[i] == p[6:0]) return 1;
        return 2;
    endfunction

    function automatic int model_num(input logic [7:0] p);
        for (int i = 0; i < 9; i++)
            if (pat_tab[i] == p[6:0]) return p[7] ? -dig_tab[i] : dig_tab[i];
        return 0;
    endfunction

    logic       m_ready = 1'b0;
    logic [7:0] m_prev;
    int         m_run;
    logic [1:0] m_state;
    logic [3:0] m_value;
    logic       m_valid;
    logic       m_error;
    logic [7:0] m_count;
    logic       m_have;

    // Reference: a pattern is accepted on the edge where it has been seen
    // for SC+1 consecutive edges since it first appeared.
    always @(posedge clk_2) begin
        if (!rst_n) begin
            m_ready <= 1'b1;
            m_prev  <= 8'h00;
            m_run   <= 0;
            m_state <= 2'd0;
            m_value <= 4'd0;
            m_valid <= 1'b0;
            m_error <= 1'b0;
            m_count <= 8'd0;
            m_have  <= 1'b0;
        end else begin
            m_prev <= bus.seg_in;
            if (bus.seg_in != m_prev) begin
                m_run   <= 1;
                m_state <= 2'd1;
                m_valid <= 1'b0;
                m_error <= 1'b0;
            end else begin
                if (m_run < 100) m_run <= m_run + 1;
                if (m_state == 2'd1 && m_run == SC) begin
                    if (model_kind(m_prev) == 0) begin
                        m_state <= 2'd0;
                        m_valid <= 1'b0;
                        m_error <= 1'b0;
                    end else if (model_kind(m_prev) == 1) begin
                        if (!m_have || m_value != 4'(model_num(m_prev))) m_count <= m_count + 8'd1;
                        m_value <= 4'(model_num(m_prev));
                        m_have  <= 1'b1;
                        m_valid <= 1'b1;
                        m_error <= 1'b0;
                        m_state <= 2'd2;
                    end else begin
                        m_state <= 2'd3;
                        m_valid <= 1'b0;
                        m_error <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk_2) begin
        if (m_ready) begin
            checks++;
            if (bus.value !== m_value || bus.valid !== m_valid || bus.error !== m_error ||
                bus.change_count !== m_count || bus.state !== m_state) begin
                errors++;
                $display("[TB] FAIL cycle_outputs t=%0t: got val=%h vld=%b err=%b cnt=%0d st=%0d, expected val=%h vld=%b err=%b cnt=%0d st=%0d",
                         $time, bus.value, bus.valid, bus.error, bus.change_count, bus.state,
                         m_value, m_valid, m_error, m_count, m_state);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] pat, input int edges);
        bus.seg_in = pat;
        repeat (edges) @(posedge clk_2);
        #2;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_2);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ev, input logic evld,
                               input logic eerr, input logic [7:0] ecnt, input logic [1:0] est);
        checks++;
        if (bus.value !== ev || bus.valid !== evld || bus.error !== eerr ||
            bus.change_count !== ecnt || bus.state !== est) begin
            errors++;
            $display("[TB] FAIL %s: got val=%h vld=%b err=%b cnt=%0d st=%0d, expected val=%h vld=%b err=%b cnt=%0d st=%0d",
                     name, bus.value, bus.valid, bus.error, bus.change_count, bus.state,
                     ev, evld, eerr, ecnt, est);
        end
        checks++;
        if (m_value !== ev || m_valid !== evld || m_error !== eerr ||
            m_count !== ecnt || m_state !== est) begin
            errors++;
            $display("[TB] FAIL model_%s: got val=%h vld=%b err=%b cnt=%0d st=%0d, expected val=%h vld=%b err=%b cnt=%0d st=%0d",
                     name, m_value, m_valid, m_error, m_count, m_state, ev, evld, eerr, ecnt, est);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.seg_in = 8'h4F;
        repeat (2) @(posedge clk_2);
        #2;
        checkOutput("reset", 4'd0, 1'b0, 1'b0, 8'd0, 2'd0);
        rst_n = 1'b1;

        $display("[TB] reset release and latency");
        applyStimulus(8'h4F, 4);
        checkOutput("one_short_of_lock", 4'd0, 1'b0, 1'b0, 8'd0, 2'd1);
        applyStimulus(8'h4F, 1);
        checkOutput("lock_3", 4'd3, 1'b1, 1'b0, 8'd1, 2'd2);

        $display("[TB] negative digits");
        resetDut();
        applyStimulus(8'hE6, 5);
        checkOutput("lock_minus4", 4'hC, 1'b1, 1'b0, 8'd1, 2'd2);
        applyStimulus(8'h87, 5);
        checkOutput("lock_minus7", 4'h9, 1'b1, 1'b0, 8'd2, 2'd2);

        $display("[TB] glitch");
        applyStimulus(8'h06, 5);
        checkOutput("lock_1", 4'd1, 1'b1, 1'b0, 8'd3, 2'd2);
        applyStimulus(8'h07, 1);
        checkOutput("glitch_edge", 4'd1, 1'b0, 1'b0, 8'd3, 2'd1);
        applyStimulus(8'h06, 4);
        checkOutput("glitch_settling", 4'd1, 1'b0, 1'b0, 8'd3, 2'd1);
        applyStimulus(8'h06, 1);
        checkOutput("glitch_relock", 4'd1, 1'b1, 1'b0, 8'd3, 2'd2);

        $display("[TB] illegal and blank");
        applyStimulus(8'h7F, 5);
        checkOutput("illegal_7F", 4'd1, 1'b0, 1'b1, 8'd3, 2'd3);
        applyStimulus(8'h7F, 3);
        checkOutput("error_holds", 4'd1, 1'b0, 1'b1, 8'd3, 2'd3);
        applyStimulus(8'h00, 5);
        checkOutput("blank", 4'd1, 1'b0, 1'b0, 8'd3, 2'd0);
        applyStimulus(8'h80, 5);
        checkOutput("lone_minus", 4'd1, 1'b0, 1'b1, 8'd3, 2'd3);

        $display("[TB] equivalences");
        applyStimulus(8'hBF, 5);
        checkOutput("minus_zero", 4'd0, 1'b1, 1'b0, 8'd4, 2'd2);
        applyStimulus(8'h3F, 5);
        checkOutput("plus_zero", 4'd0, 1'b1, 1'b0, 8'd4, 2'd2);
        applyStimulus(8'h3D, 5);
        checkOutput("six_3D", 4'd6, 1'b1, 1'b0, 8'd5, 2'd2);
        applyStimulus(8'h7D, 5);
        checkOutput("six_7D", 4'd6, 1'b1, 1'b0, 8'd5, 2'd2);

        $display("[TB] change_count wrap");
        resetDut();
        for (int i = 0; i < 255; i++) applyStimulus((i % 2 == 1) ? 8'h5B : 8'h06, 5);
        checkOutput("count_255", 4'd1, 1'b1, 1'b0, 8'd255, 2'd2);
        applyStimulus(8'h5B, 5);
        checkOutput("count_wrap", 4'd2, 1'b1, 1'b0, 8'd0, 2'd2);

        $display("[TB] reset mid-settle");
        applyStimulus(8'h4F, 1);
        checkOutput("settle_start", 4'd2, 1'b0, 1'b0, 8'd0, 2'd1);
        rst_n = 1'b0;
        @(posedge clk_2);
        #2;
        checkOutput("mid_settle_reset", 4'd0, 1'b0, 1'b0, 8'd0, 2'd0);
        rst_n = 1'b1;
        applyStimulus(8'h4F, 5);
        checkOutput("relock_after_reset", 4'd3, 1'b1, 1'b0, 8'd1, 2'd2);

        @(negedge clk_2);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Reads an 8-bit seven-segment pattern (bit 7 = minus sign via the decimal point, bits 6:0 = segments g..a) and recovers the signed integer it shows. The pattern must be stable for a programmable number of cycles before it is decoded. The block is the receive-side counterpart of the board's integer-to-7-segment display path. It drives `LED`-class outputs and LCD debug fields in the `top` wrapper, with `SWI` typically feeding `seg_in`.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive identical samples required before decoding. Legal range 1..15.
- `clk_2`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `seg_in`  input  8  pattern under observation.
- `value`  output  4  decoded integer, two's complement, range -7..+7.
- `valid`  output  1  `value` reflects the currently locked pattern.
- `error`  output  1  the stable pattern is not a legal digit.
- `change_count`  output  8  number of accepted value changes; wraps 255→0.
- `state`  output  2  FSM state for LCD debug: IDLE=0, SETTLE=1, LOCKED=2, ERROR=3.

## Operation
- **Sample register.** `s_reg` loads `seg_in` on every edge.
- **Stability counter.** 4 bits.
  - If `seg_in` differs from `s_reg` at an edge, `cnt` clears to 0.
  - Otherwise `cnt` increments, saturating at `SETTLE_CYCLES-1`.
- **Legal patterns (bits 6:0).**
  - 0 = 7'h3F
  - 1 = 7'h06
  - 2 = 7'h5B
  - 3 = 7'h4F
  - 4 = 7'h66
  - 5 = 7'h6D
  - 6 = 7'h3D or 7'h7D
  - 7 = 7'h07
  - Magnitude is negated when bit 7 = 1.
  - 8'h80|7'h3F ("-0") decodes to 0 and is legal.
  - 8'h00 (blank) is neither a digit nor an error.
  - Every other pattern is illegal, including 8'h80 alone.
- **FSM.**
  - IDLE → SETTLE: `seg_in` ≠ `s_reg`.
  - SETTLE → SETTLE: a change is seen; `cnt` restarts.
  - SETTLE exits when `cnt == SETTLE_CYCLES-1` and `seg_in == s_reg`. The destination depends on `s_reg`:
    - blank → IDLE
    - legal → LOCKED
    - illegal → ERROR
  - LOCKED / ERROR → SETTLE: `seg_in` ≠ `s_reg`.
  - LOCKED / ERROR stay put while the input is unchanged. There is no re-decode and no re-count.
- **Outputs.**
  - On entry to LOCKED: `value` ← decoded integer, `valid` ← 1, `error` ← 0.
  - On entry to ERROR: `error` ← 1, `valid` ← 0, `value` holds its last accepted integer.
  - On entry to IDLE: `valid` ← 0, `error` ← 0, `value` holds.
  - On entry to SETTLE from any state: `valid` ← 0 and `error` ← 0 on that same edge; `value` holds.
- **change_count.**
  - Increments by 1 on an entry to LOCKED when either:
    - no value has been accepted since reset (internal flag `have_value` = 0), or
    - the decoded value differs from the held `value`.
  - Re-locking on the same integer does not count. For example, -0 followed by 0 both decode to 0, so the second lock does not count.
  - Wrap-around: 255 + 1 = 0, with no flag.

## Timing
- **Reset** (`rst_n` = 0 at an edge): state = IDLE, `s_reg` = 0, `cnt` = 0, `value` = 0, `valid` = 0, `error` = 0, `change_count` = 0, `have_value` = 0. Reset overrides all other activity, including a reset asserted mid-SETTLE.
- **Latency.**
  - A new pattern P first present at edge E0 enters SETTLE at E0.
  - If P stays present through edge E(`SETTLE_CYCLES`), outputs reflect P immediately after that edge: `SETTLE_CYCLES+1` edges in total.
  - With `SETTLE_CYCLES` = 1, the lock edge immediately follows the detection edge.
- **Glitch rejection.** Any change inside the window restarts it from the new pattern. A one-cycle glitch while LOCKED drops `valid` for at least `SETTLE_CYCLES+1` cycles, then re-locks without counting if the decoded value is unchanged.
- **Output registering.** All outputs are registered. No output depends combinationally on `seg_in`.

## Test plan
1. **Reset.**
   - Stimulus: hold `rst_n` = 0 for 2 cycles with `seg_in` = 8'h4F.
   - Required: `value` = 0, `valid` = 0, `error` = 0, `change_count` = 0, `state` = 0 throughout.
   - Then release reset and hold 8'h4F.
   - Required: `valid` rises after the 5th edge with `value` = 3 and `change_count` = 1.
2. **Negative digits.**
   - Stimulus: 8'hE6 held 5 edges, then 8'h87 held 5 edges.
   - Required: `value` = 4'hC (-4) then 4'h9 (-7); `change_count` = 1 then 2.
3. **Glitch.**
   - Stimulus: lock 8'h06, pulse 8'h07 for 1 cycle, return to 8'h06.
   - Required: `valid` = 0 from the detection edge until re-lock; final `value` = 1; `change_count` unchanged.
4. **Illegal and blank.**
   - Stimulus: 8'h7F held 5 edges.
   - Required: `error` = 1, `valid` = 0, `value` holds the prior integer, `state` = 3.
   - Stimulus: then 8'h00 held 5 edges.
   - Required: `error` = 0, `valid` = 0, `state` = 0.
5. **Equivalences.**
   - Stimulus: lock 8'hBF (-0), then lock 8'h3F.
   - Required: both give `value` = 0; only the first counts.
   - Stimulus: lock 8'h3D, then lock 8'h7D.
   - Required: both give `value` = 6; only the first counts.
6. **Wrap and reset mid-settle.**
   - Stimulus: alternate 8'h06 and 8'h5B locks 256 times.
   - Required: `change_count` wraps to 0.
   - Stimulus: assert `rst_n` = 0 at the 2nd edge of a SETTLE.
   - Required: all outputs return to their reset values on that edge.
